// File: rtl/mac_div.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : mac_div
//  Purpose  : Sequential restoring divider. Splits an accumulated DW-bit value
//             into quotient and remainder by a VW-bit divisor, one quotient
//             bit per clock.
//  Ports    : clk        rising-edge clock
//             rst        asynchronous active-high reset
//             start      request, sampled only while idle
//             dividend   DW-bit numerator, sampled on the accepting edge
//             divisor    VW-bit unsigned denominator, sampled on accept
//             busy       high while a division is in progress
//             done       one-cycle pulse, results valid
//             quotient   DW-bit unsigned quotient (held until next result)
//             remainder  VW-bit unsigned remainder (held until next result)
//             div_zero   set with done when the divisor was zero
//  Revision : 1.0  initial release
// ============================================================================
module mac_div #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [VW-1:0] divisor_q, divisor_d;
  logic [VW-1:0] prem_q, prem_d;     // partial remainder, always < divisor
  logic [DW-1:0] sreg_q, sreg_d;     // dividend bits out, quotient bits in
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_q, dz_d;         // accepted request had a zero divisor
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          divz_q, divz_d;

  // The shifted partial remainder needs one extra bit: 2*prem+1 can reach
  // 2*divisor-1. Its difference with the divisor always lies within
  // (-2^VW, 2^VW), so the top bit of the trial is a clean borrow flag.
  logic [VW:0]   w_shift;
  logic [VW:0]   w_trial;
  logic          w_fit;
  logic [VW-1:0] w_prem_next;
  logic [DW-1:0] w_sreg_next;

  assign w_shift     = {prem_q, sreg_q[DW-1]};
  assign w_trial     = w_shift - {1'b0, divisor_q};
  assign w_fit       = ~w_trial[VW];
  assign w_prem_next = w_fit ? w_trial[VW-1:0] : w_shift[VW-1:0];
  assign w_sreg_next = {sreg_q[DW-2:0], w_fit};

  always_comb begin
    state_d   = state_q;
    divisor_d = divisor_q;
    prem_d    = prem_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    dz_d      = dz_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    divz_d    = divz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          divisor_d = divisor;
          prem_d    = '0;
          sreg_d    = dividend;
          cnt_d     = CW'(DW - 1);
          dz_d      = (divisor == '0);
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
        if (dz_q) begin
          // Zero divisor spends a single RUN cycle so done lands after E1.
          quot_d  = '1;
          rem_d   = '0;
          divz_d  = 1'b1;
          dz_d    = 1'b0;
          state_d = S_DONE;
        end else begin
          prem_d = w_prem_next;
          sreg_d = w_sreg_next;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            quot_d  = w_sreg_next;
            rem_d   = w_prem_next;
            divz_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      divisor_q <= '0;
      prem_q    <= '0;
      sreg_q    <= '0;
      cnt_q     <= '0;
      dz_q      <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      divz_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      divisor_q <= divisor_d;
      prem_q    <= prem_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      dz_q      <= dz_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      divz_q    <= divz_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = divz_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_div.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mac_div
//  Purpose  : Self-checking bench for mac_div. Expected results come from
//             plain integer division and are queued when a request is issued;
//             a monitor pops and compares on every done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mac_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_zero;

  mac_div #(.DW(16), .VW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   done_times[$];
  int   checks  = 0;
  int   errors  = 0;
  int   ncyc    = 0;
  int   done_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input int unsigned a, input int unsigned d);
    exp_t e;
    if (d == 0) begin
      e.q  = 16'hFFFF;
      e.r  = 8'h00;
      e.dz = 1'b1;
    end else begin
      e.q  = 16'(a / d);
      e.r  = 8'(a % d);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: compares each done pulse against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (done) begin
        done_cnt++;
        done_times.push_back(ncyc);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got q=%h r=%h dz=%b at cycle %0d, no request pending",
                   quotient, remainder, div_zero, ncyc);
        end else begin
          e = sb.pop_front();
          if (quotient !== e.q || remainder !== e.r || div_zero !== e.dz) begin
            errors++;
            $display("FAIL result: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b",
                     quotient, remainder, div_zero, e.q, e.r, e.dz);
          end
        end
      end
    end
  end

  // Issue one request and check its latency and busy duration.
  task automatic run_div(input logic [15:0] a, input logic [7:0] d);
    int k;
    int busy_n;
    int exp_lat;
    exp_lat = (d == 0) ? 2 : 17;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = d;
    sb.push_back(model(a, d));
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    k = 1;
    busy_n = 0;
    while (!done && k < 60) begin
      if (busy) busy_n++;
      @(negedge clk);
      k++;
    end
    checks++;
    if (!done || k != exp_lat) begin
      errors++;
      $display("FAIL latency %0d/%0d: got done after %0d cycles (done=%b), expected %0d",
               a, d, k, done, exp_lat);
    end
    checks++;
    if (busy_n != exp_lat - 1) begin
      errors++;
      $display("FAIL busy_len %0d/%0d: got %0d busy cycles, expected %0d",
               a, d, busy_n, exp_lat - 1);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  initial begin
    int base;
    int k;
    logic [15:0] ra;
    logic [7:0]  rd;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    check_int("reset_quotient", int'(quotient), 0);
    check_int("reset_remainder", int'(remainder), 0);
    check_bit("reset_div_zero", div_zero, 1'b0);
    rst = 1'b0;

    // Directed cases
    run_div(16'd1000, 8'd7);
    run_div(16'hFFFF, 8'hFF);
    run_div(16'hFFFF, 8'h01);
    run_div(16'd5, 8'd10);
    run_div(16'h1234, 8'd0);
    run_div(16'd20, 8'd4);

    // Randomised cases, including zero divisors and small dividends
    for (int i = 0; i < 30; i++) begin
      rd = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      ra = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
      run_div(ra, rd);
    end

    // Second start during RUN must be ignored
    base = done_cnt;
    @(negedge clk);
    start = 1'b1; dividend = 16'd100; divisor = 8'd3;
    sb.push_back(model(100, 3));
    @(negedge clk);
    start = 1'b0; dividend = 16'hBEEF;
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 16'd50; divisor = 8'd5;
    @(negedge clk);
    start = 1'b0; dividend = 16'hCAFE; divisor = 8'd1;
    repeat (40) @(negedge clk);
    check_int("overlap_done_count", done_cnt - base, 1);
    check_int("overlap_quotient", int'(quotient), 33);

    // Asynchronous reset in the middle of a run
    base = done_cnt;
    @(negedge clk);
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    sb.push_back(model(1000, 7));
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_done", done, 1'b0);
    check_int("abort_quotient", int'(quotient), 0);
    check_int("abort_remainder", int'(remainder), 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_int("abort_no_done", done_cnt - base, 0);
    run_div(16'd9, 8'd2);

    // start held high: one result every 18 cycles
    base = done_times.size();
    @(negedge clk);
    start = 1'b1; dividend = 16'd200; divisor = 8'd9;
    for (int c = 0; c < 40; c++) begin
      if (c % 18 == 0) sb.push_back(model(200, 9));
      @(negedge clk);
    end
    start = 1'b0;
    k = 0;
    while (done_times.size() - base < 3 && k < 60) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    check_int("stream_count", done_times.size() - base, 3);
    if (done_times.size() - base >= 3) begin
      check_int("stream_gap1", done_times[base+1] - done_times[base], 18);
      check_int("stream_gap2", done_times[base+2] - done_times[base+1], 18);
    end
    check_int("queue_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
